// File: rtl/ibus_cache.sv
// Direct-mapped, single-word-line, read-only instruction cache between the CPU iBus
// and the bus_arb a-port. Misses stall while the slow SPI-backed fetch completes.
module ibus_cache #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              wb_cpu_cyc,
  input  logic [31:0]       wb_cpu_adr,
  output logic              wb_cpu_ack,
  output logic [31:0]       wb_cpu_rdt,
  output logic              wb_mem_cyc,
  output logic [31:0]       wb_mem_adr,
  input  logic              wb_mem_ack,
  input  logic [31:0]       wb_mem_rdt,
  input  logic              flush,
  output logic [CNT_W-1:0]  hits,
  output logic [CNT_W-1:0]  misses
);

  localparam int unsigned LINES = 2 ** IDX_W;
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:2]       adr_q, adr_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              flush_seen_q, flush_seen_d;

  logic              cpu_ack_d;
  logic [31:0]       cpu_rdt_d;
  logic              mem_cyc_d;
  logic [31:0]       mem_adr_d;
  logic [CNT_W-1:0]  hits_d, misses_d;

  logic [31:0]       data_ram [LINES];
  logic [TAG_W-1:0]  tag_ram  [LINES];
  logic [31:0]       ram_rdt;
  logic [TAG_W-1:0]  ram_tag;
  logic              ram_rd_c, ram_wr_c, hit_c;

  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic              unused_adr_c;

  assign idx_q        = adr_q[IDX_W+1:2];
  assign tag_q        = adr_q[ADDR_W-1:IDX_W+2];
  assign unused_adr_c = ^wb_cpu_adr[1:0];
  // A flush sampled in LOOKUP must not let a stale line hit.
  assign hit_c        = valid_q[idx_q] && (ram_tag == tag_q) && !flush;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    valid_d      = valid_q;
    flush_seen_d = flush_seen_q;
    cpu_ack_d    = 1'b0;
    cpu_rdt_d    = wb_cpu_rdt;
    mem_cyc_d    = wb_mem_cyc;
    mem_adr_d    = wb_mem_adr;
    hits_d       = hits;
    misses_d     = misses;
    ram_rd_c     = 1'b0;
    ram_wr_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (wb_cpu_cyc && !wb_cpu_ack) begin
          adr_d    = wb_cpu_adr[31:2];
          ram_rd_c = 1'b1;
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_c) begin
          cpu_rdt_d = ram_rdt;
          cpu_ack_d = 1'b1;
          if (hits != {CNT_W{1'b1}}) hits_d = hits + CNT_W'(1);
          state_d   = RESP;
        end else begin
          mem_cyc_d    = 1'b1;
          mem_adr_d    = {adr_q, 2'b00};
          flush_seen_d = 1'b0;
          if (misses != {CNT_W{1'b1}}) misses_d = misses + CNT_W'(1);
          state_d      = FILL;
        end
      end
      FILL: begin
        if (flush) flush_seen_d = 1'b1;
        if (wb_mem_ack) begin
          mem_cyc_d = 1'b0;
          ram_wr_c  = 1'b1;
          if (!flush_seen_q) valid_d[idx_q] = 1'b1;
          cpu_rdt_d = wb_mem_rdt;
          cpu_ack_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush beats a same-edge fill
    if (flush) valid_d = '0;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q      <= IDLE;
      adr_q        <= '0;
      valid_q      <= '0;
      flush_seen_q <= 1'b0;
      wb_cpu_ack   <= 1'b0;
      wb_cpu_rdt   <= '0;
      wb_mem_cyc   <= 1'b0;
      wb_mem_adr   <= '0;
      hits         <= '0;
      misses       <= '0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      valid_q      <= valid_d;
      flush_seen_q <= flush_seen_d;
      wb_cpu_ack   <= cpu_ack_d;
      wb_cpu_rdt   <= cpu_rdt_d;
      wb_mem_cyc   <= mem_cyc_d;
      wb_mem_adr   <= mem_adr_d;
      hits         <= hits_d;
      misses       <= misses_d;
    end
  end

  // Data/tag RAM: synchronous read, no reset on contents
  always_ff @(posedge wb_clk) begin
    if (ram_rd_c) begin
      ram_rdt <= data_ram[wb_cpu_adr[IDX_W+1:2]];
      ram_tag <= tag_ram[wb_cpu_adr[IDX_W+1:2]];
    end
    if (ram_wr_c && !wb_rst) begin
      data_ram[idx_q] <= wb_mem_rdt;
      tag_ram[idx_q]  <= tag_q;
    end
  end

endmodule

// File: tb/tb_ibus_cache.sv
// Bench for ibus_cache: directed fetches against a line-level cache model and a
// delayed memory responder, with per-cycle protocol checks and literal pins.
module tb_ibus_cache;

  localparam int unsigned IDX_W  = 6;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LINES  = 2 ** IDX_W;
  localparam int unsigned CMAX   = 2 ** CNT_W - 1;

  logic              wb_clk = 1'b0;
  logic              wb_rst;
  logic              wb_cpu_cyc;
  logic [31:0]       wb_cpu_adr;
  logic              wb_cpu_ack;
  logic [31:0]       wb_cpu_rdt;
  logic              wb_mem_cyc;
  logic [31:0]       wb_mem_adr;
  logic              wb_mem_ack;
  logic [31:0]       wb_mem_rdt;
  logic              flush;
  logic [CNT_W-1:0]  hits;
  logic [CNT_W-1:0]  misses;

  always #5 wb_clk = ~wb_clk;

  ibus_cache #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .wb_cpu_cyc (wb_cpu_cyc),
    .wb_cpu_adr (wb_cpu_adr),
    .wb_cpu_ack (wb_cpu_ack),
    .wb_cpu_rdt (wb_cpu_rdt),
    .wb_mem_cyc (wb_mem_cyc),
    .wb_mem_adr (wb_mem_adr),
    .wb_mem_ack (wb_mem_ack),
    .wb_mem_rdt (wb_mem_rdt),
    .flush      (flush),
    .hits       (hits),
    .misses     (misses)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Backing memory keyed by word address within the significant range
  logic [31:0] mem_words [int unsigned];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int unsigned k;
    k = (a % (32'd1 << ADDR_W)) / 4;
    if (mem_words.exists(k)) return mem_words[k];
    return 32'h0BAD_0000 ^ (k * 32'h0000_9E37);
  endfunction

  // Cache model: which word each line holds, counters as plain saturating ints
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  int unsigned m_hits, m_misses;

  function automatic bit m_lookup(input logic [31:0] a);
    int unsigned idx, tg;
    idx = (a / 4) % LINES;
    tg  = (a % (32'd1 << ADDR_W)) >> (IDX_W + 2);
    return m_valid[idx] && (m_tag[idx] == tg);
  endfunction

  task automatic m_fill(input logic [31:0] a);
    int unsigned idx;
    idx = (a / 4) % LINES;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = (a % (32'd1 << ADDR_W)) >> (IDX_W + 2);
  endtask

  task automatic m_flush();
    for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
  endtask

  // Memory responder: acks mem_delay cycles after seeing a request, even if it was aborted
  int mem_delay = 70;
  int mem_reqs  = 0;
  bit resp_busy = 1'b0;

  initial begin
    logic [31:0] a;
    wb_mem_ack = 1'b0;
    wb_mem_rdt = 32'h0;
    forever begin
      @(posedge wb_clk); #1;
      if (wb_mem_cyc && !wb_rst) begin
        resp_busy = 1'b1;
        mem_reqs++;
        a = wb_mem_adr;
        repeat (mem_delay - 1) @(posedge wb_clk);
        #1;
        wb_mem_ack = 1'b1;
        wb_mem_rdt = mem_word(a);
        @(posedge wb_clk); #1;
        wb_mem_ack = 1'b0;
        wb_mem_rdt = 32'hBAD0_BAD0;
        resp_busy  = 1'b0;
      end
    end
  end

  // Per-cycle protocol/data checks
  logic [31:0] cur_adr = 32'h0;
  logic [31:0] exp_rdt = 32'h0;
  bit          exp_hit = 1'b0;
  bit          active  = 1'b0;
  int          ack_cnt = 0;

  initial begin
    forever begin
      @(negedge wb_clk);
      if (!wb_rst) begin
        if (wb_cpu_ack) begin
          ack_cnt++;
          check("ack_without_cyc", 32'(wb_cpu_cyc), 32'd1);
          check("cpu_rdt", wb_cpu_rdt, exp_rdt);
        end
        if (wb_mem_cyc)
          check("mem_adr", wb_mem_adr, {cur_adr[31:2], 2'b00});
        if (active && exp_hit)
          check("mem_cyc_on_hit", 32'(wb_mem_cyc), 32'd0);
      end
    end
  end

  int n_fetch = 0;

  task automatic wait_resp_idle();
    for (int c = 0; c < 300 && resp_busy; c++) @(posedge wb_clk);
    #1;
  endtask

  // One CPU fetch; flush_at > 0 pulses flush that many cycles after cyc rises
  task automatic fetch(input logic [31:0] a, input int flush_at, output bit was_hit,
                       output logic [31:0] got_rdt);
    bit got, flushed;
    int lat, reqs0;
    got = 1'b0; flushed = 1'b0; lat = 0;
    wait_resp_idle();
    reqs0   = mem_reqs;
    exp_hit = m_lookup(a);
    exp_rdt = mem_word(a);
    cur_adr = a;
    was_hit = exp_hit;
    got_rdt = 32'h0;
    active  = 1'b1;
    n_fetch++;
    @(posedge wb_clk); #1;
    wb_cpu_cyc = 1'b1;
    wb_cpu_adr = a;
    for (int c = 1; c <= 400 && !got; c++) begin
      @(posedge wb_clk); #1;
      if (flush) flush = 1'b0;
      if (wb_cpu_ack) begin
        got     = 1'b1;
        lat     = c;
        got_rdt = wb_cpu_rdt;
      end else if (c == flush_at) begin
        flush   = 1'b1;
        flushed = 1'b1;
        m_flush();
      end
    end
    check("ack_arrived", 32'(got), 32'd1);
    if (exp_hit) begin
      if (m_hits < CMAX) m_hits++;
    end else begin
      if (m_misses < CMAX) m_misses++;
      if (!flushed) m_fill(a);
    end
    check("ack_latency", 32'(lat), exp_hit ? 32'd2 : 32'(mem_delay + 2));
    check("mem_requests", 32'(mem_reqs - reqs0), exp_hit ? 32'd0 : 32'd1);
    check("hits", 32'(hits), 32'(m_hits));
    check("misses", 32'(misses), 32'(m_misses));
    @(posedge wb_clk); #1;
    check("ack_single_pulse", 32'(wb_cpu_ack), 32'd0);
    wb_cpu_cyc = 1'b0;
    active     = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge wb_clk); #1 flush = 1'b1;
    @(posedge wb_clk); #1 flush = 1'b0;
    m_flush();
  endtask

  bit          h;
  logic [31:0] r;
  int          acks_before;

  initial begin
    wb_rst = 1'b1; wb_cpu_cyc = 1'b0; wb_cpu_adr = 32'h0; flush = 1'b0;
    m_flush(); m_hits = 0; m_misses = 0;
    mem_words[(32'h0010_0000 % (32'd1 << ADDR_W)) / 4] = 32'hDEAD_BEEF;
    mem_words[(32'h0010_0100 % (32'd1 << ADDR_W)) / 4] = 32'h1234_5678;
    repeat (3) @(posedge wb_clk);
    #1;
    check("rst_cpu_ack", 32'(wb_cpu_ack), 32'd0);
    check("rst_cpu_rdt", wb_cpu_rdt, 32'd0);
    check("rst_mem_cyc", 32'(wb_mem_cyc), 32'd0);
    check("rst_mem_adr", wb_mem_adr, 32'd0);
    check("rst_hits", 32'(hits), 32'd0);
    check("rst_misses", 32'(misses), 32'd0);
    wb_rst = 1'b0;

    // Cold miss, then hit, then alias above ADDR_W hits too
    fetch(32'h0010_0000, 0, h, r);
    check("t1_miss", 32'(h), 32'd0);
    check("t1_rdt", r, 32'hDEAD_BEEF);
    check("t1_misses", 32'(misses), 32'd1);
    check("t1_hits", 32'(hits), 32'd0);
    fetch(32'h0010_0000, 0, h, r);
    check("t2_hit", 32'(h), 32'd1);
    check("t2_rdt", r, 32'hDEAD_BEEF);
    check("t2_hits", 32'(hits), 32'd1);
    fetch(32'hFF10_0002, 0, h, r);
    check("alias_hit_rdt", r, 32'hDEAD_BEEF);

    // Same index, different tag evicts; a neighbouring index does not
    fetch(32'h0010_0100, 0, h, r);
    check("t3_rdt", r, 32'h1234_5678);
    fetch(32'h0010_0004, 0, h, r);
    fetch(32'h0010_0000, 0, h, r);
    check("t3_evicted", 32'(h), 32'd0);
    fetch(32'h0010_0004, 0, h, r);
    check("t3_neighbour_hit", 32'(h), 32'd1);
    check("t3_misses", 32'(misses), 32'd4);

    // Flush invalidates; flush during a fill delivers data but leaves the line invalid
    pulse_flush();
    fetch(32'h0010_0000, 0, h, r);
    check("t4_flushed_miss", 32'(h), 32'd0);
    fetch(32'h0010_0008, 10, h, r);
    fetch(32'h0010_0008, 0, h, r);
    check("t4_fill_flush_miss", 32'(h), 32'd0);
    fetch(32'h0010_0008, 0, h, r);
    check("t4_refill_hit", 32'(h), 32'd1);

    // Reset mid-FILL with a late ack from the bus
    wait_resp_idle();
    exp_hit = 1'b0; cur_adr = 32'h0010_0010; exp_rdt = mem_word(32'h0010_0010);
    @(posedge wb_clk); #1;
    wb_cpu_cyc = 1'b1; wb_cpu_adr = 32'h0010_0010;
    for (int c = 0; c < 20 && !wb_mem_cyc; c++) begin
      @(posedge wb_clk); #1;
    end
    check("t5_fill_started", 32'(wb_mem_cyc), 32'd1);
    repeat (5) @(posedge wb_clk);
    #1;
    acks_before = ack_cnt;
    wb_rst = 1'b1; wb_cpu_cyc = 1'b0;
    @(posedge wb_clk); #1;
    check("t5_mem_cyc_drop", 32'(wb_mem_cyc), 32'd0);
    repeat (5) @(posedge wb_clk);
    #1;
    wb_rst = 1'b0;
    m_flush(); m_hits = 0; m_misses = 0;
    check("t5_hits_clr", 32'(hits), 32'd0);
    check("t5_misses_clr", 32'(misses), 32'd0);
    for (int c = 0; c < 200 && resp_busy; c++) begin
      @(posedge wb_clk); #1;
    end
    check("t5_resp_done", 32'(resp_busy), 32'd0);
    repeat (3) @(posedge wb_clk);
    #1;
    check("t5_no_cpu_ack", 32'(ack_cnt - acks_before), 32'd0);
    fetch(32'h0010_0000, 0, h, r);
    check("t5_cold_miss", 32'(h), 32'd0);
    check("t5_misses", 32'(misses), 32'd1);

    // Hit counter saturation
    for (int i = 0; i < int'(CMAX) + 6; i++) fetch(32'h0010_0000, 0, h, r);
    check("t6_hits_sat", 32'(hits), 32'(CMAX));
    check("t6_model_sat", 32'(m_hits), 32'd15);
    check("t6_misses", 32'(misses), 32'd1);

    repeat (3) @(posedge wb_clk);
    check("ack_count", 32'(ack_cnt), 32'(n_fetch));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
